load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock shared with the data memory.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  access request present.
REQ-005 req_ready  output  1  unit idle; a request is accepted on the rising edge where req_valid=1 and req_ready=1.
REQ-006 req_op  input  3  access type: 000 LB, 001 LH, 010 LW, 011 SB, 100 LBU, 101 LHU, 110 SH, 111 SW.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data; the byte or halfword is taken from the low bits.
REQ-009 resp_valid  output  1  one-cycle completion pulse.
REQ-010 resp_data  output  32  extended load result; 0 for stores and errors.
REQ-011 resp_err  output  1  misaligned access; valid with resp_valid.
REQ-012 err_count  output  8  saturating count of misaligned requests.
REQ-013 mem_addr, mem_wdata  output  32 each  word-aligned address and write data to the data memory.
REQ-014 mem_read, mem_write  output  1 each  data-memory strobes.
REQ-015 mem_rdata  input  32  data-memory read data, valid in the cycle after a mem_read edge.

Function
REQ-016 Memory SHALL be big-endian: byte offset 0 maps to bits [31:24], and offset 3 maps to bits [7:0]; a halfword at offset 0 maps to [31:16], and at offset 2 maps to [15:0].
REQ-017 The unit SHALL implement the states IDLE, RD, LEXT, MERGE, WR and RESP, and req_ready SHALL be 1 only in IDLE.
REQ-018 On acceptance, the unit SHALL latch op, addr and wdata; these latched values SHALL be ignored after acceptance even if the inputs change.
REQ-019 Misalignment SHALL be defined as addr[0]=1 for LH, LHU or SH, or addr[1:0]!=0 for LW or SW.
REQ-020 A misaligned request SHALL go IDLE->RESP with resp_err=1 and resp_data=0, and SHALL perform no memory access.
REQ-021 For each misaligned request, err_count SHALL increment by 1 and SHALL saturate at 255.
REQ-022 Loads SHALL follow IDLE->RD->LEXT->RESP->IDLE, giving resp_valid 3 cycles after the accept edge.
REQ-023 LB and LH SHALL sign-extend the selected field; LBU and LHU SHALL zero-extend it; LW SHALL pass the whole word.
REQ-024 SW SHALL follow IDLE->WR->RESP->IDLE, with mem_wdata equal to the latched wdata.
REQ-025 SB and SH SHALL follow IDLE->RD->MERGE->WR->RESP->IDLE as a read-modify-write.
REQ-026 In MERGE, the unit SHALL register mem_rdata with the target byte or halfword replaced by wdata[7:0] or wdata[15:0] and all other bytes unchanged.
REQ-027 mem_read SHALL be 1 only in RD, and mem_write SHALL be 1 only in WR; they SHALL never be 1 together, and each SHALL be high for exactly one cycle per access.
REQ-028 mem_addr SHALL equal {addr[31:2],2'b00} in RD and WR and 0 otherwise; mem_wdata SHALL be 0 outside WR.
REQ-029 All mem_* outputs SHALL be functions of state and registers only, with no combinational path from mem_rdata or req_*.
REQ-030 resp_valid SHALL be 1 only in RESP, and resp_data and resp_err SHALL be held stable during that cycle.
REQ-031 A request presented while req_ready=0 SHALL be ignored, with no queuing.
REQ-032 Back-to-back accesses SHALL be allowed: a new request may be accepted on the first IDLE cycle after RESP.

Reset
REQ-033 While rst_n=0, the state SHALL be IDLE, req_ready=1, and all other outputs SHALL be 0, with err_count=0.
REQ-034 Reset asserted mid-operation SHALL abandon the access immediately, without waiting for a clock edge.
REQ-035 Reset asserted before the WR edge SHALL leave memory unmodified, and no resp_valid SHALL be produced for the abandoned access.

Verification
REQ-036 SW 0x14 with data 0x8122F344 -> mem_write=1 for one cycle with mem_addr=0x14 and mem_wdata=0x8122F344; resp_valid follows 2 cycles after accept with resp_err=0.
REQ-037 Loads with word 0x8122F344 at 0x14 -> LB 0x14 = 0xFFFFFF81, LBU 0x14 = 0x00000081, LH 0x16 = 0xFFFFF344, LHU 0x16 = 0x0000F344, LW 0x14 = 0x8122F344, each with resp_valid 3 cycles after accept.
REQ-038 SB 0x15 with data 0x000000AA -> RD then WR with mem_wdata=0x81AAF344 and resp_valid 4 cycles after accept; a following LW 0x14 returns 0x81AAF344.
REQ-039 SH 0x17 then LW 0x16 -> each returns resp_err=1 and resp_data=0 one cycle after accept; mem_read and mem_write stay 0; err_count goes 0->2; 300 misaligned requests leave err_count=255.
REQ-040 SH 0x14 with data 0x0000BEEF and rst_n pulsed low during MERGE -> mem_write is never asserted, no resp_valid occurs, req_ready=1 after reset, and LW 0x14 still returns the prior word.
REQ-041 req_valid held high with changing req_addr while busy -> only the first request is executed, and the next is accepted on the IDLE cycle after resp_valid.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
`timescale 1ns/1ps

interface load_store_unit_if;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned OpWidth   = 3;

  logic                 req_valid;
  logic                 req_ready;
  logic [OpWidth-1:0]   req_op;
  logic [DataWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_wdata;
  logic                 resp_valid;
  logic [DataWidth-1:0] resp_data;
  logic                 resp_err;
  logic [DataWidth-1:0] mem_addr;
  logic [DataWidth-1:0] mem_wdata;
  logic                 mem_read;
  logic                 mem_write;
  logic [DataWidth-1:0] mem_rdata;

  // Unit side: consumes requests and memory read data.
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  // Requester/memory side.
  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Big-endian load/store unit: byte/half/word loads with extension,
// word stores, and byte/half stores as read-modify-write.
`timescale 1ns/1ps

module load_store_unit (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus,
  output logic [7:0]       err_count
);
  localparam int unsigned DataWidth  = 32;
  localparam int unsigned CountWidth = 8;

  localparam logic [2:0] OpLb  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLw  = 3'b010;
  localparam logic [2:0] OpSb  = 3'b011;
  localparam logic [2:0] OpLbu = 3'b100;
  localparam logic [2:0] OpLhu = 3'b101;
  localparam logic [2:0] OpSh  = 3'b110;
  localparam logic [2:0] OpSw  = 3'b111;

  typedef enum logic [2:0] {IDLE, RD, LEXT, MERGE, WR, RESP} stateT;

  stateT                 state, stateNext;
  logic [2:0]            opR;
  logic [DataWidth-1:0]  addrR;
  logic [15:0]           wdataR;
  logic                  latch, errInc;
  logic [CountWidth-1:0] errCount;

  logic                 reqReady, reqReadyNext;
  logic                 respValid, respValidNext;
  logic [DataWidth-1:0] respData, respDataNext;
  logic                 respErr, respErrNext;
  logic [DataWidth-1:0] memAddr, memAddrNext;
  logic [DataWidth-1:0] memWdata, memWdataNext;
  logic                 memRead, memReadNext;
  logic                 memWrite, memWriteNext;

  function automatic logic isMisaligned(input logic [2:0] op, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (op)
      OpLh, OpLhu, OpSh: mis = off[0];
      OpLw, OpSw:        mis = (off != 2'b00);
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Select the addressed field (offset 0 is the most significant byte) and extend it.
  function automatic logic [DataWidth-1:0] extendLoad(input logic [2:0] op,
                                                      input logic [1:0] off,
                                                      input logic [DataWidth-1:0] word);
    logic [7:0]           b;
    logic [15:0]          h;
    logic [DataWidth-1:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (op)
      OpLb:    r = {{24{b[7]}}, b};
      OpLbu:   r = {24'd0, b};
      OpLh:    r = {{16{h[15]}}, h};
      OpLhu:   r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte or halfword of the fetched word with store data.
  function automatic logic [DataWidth-1:0] mergeStore(input logic [2:0] op,
                                                      input logic [1:0] off,
                                                      input logic [DataWidth-1:0] word,
                                                      input logic [15:0] wdata);
    logic [DataWidth-1:0] r;
    r = word;
    if (op == OpSb) begin
      case (off)
        2'd0:    r[31:24] = wdata[7:0];
        2'd1:    r[23:16] = wdata[7:0];
        2'd2:    r[15:8]  = wdata[7:0];
        default: r[7:0]   = wdata[7:0];
      endcase
    end else if (off[1]) begin
      r[15:0] = wdata;
    end else begin
      r[31:16] = wdata;
    end
    return r;
  endfunction

  // Next state and next registered outputs.
  always_comb begin
    stateNext     = state;
    reqReadyNext  = 1'b0;
    respValidNext = 1'b0;
    respDataNext  = '0;
    respErrNext   = 1'b0;
    memAddrNext   = '0;
    memWdataNext  = '0;
    memReadNext   = 1'b0;
    memWriteNext  = 1'b0;
    latch         = 1'b0;
    errInc        = 1'b0;
    case (state)
      IDLE: begin
        reqReadyNext = 1'b1;
        if (bus.req_valid) begin
          latch        = 1'b1;
          reqReadyNext = 1'b0;
          if (isMisaligned(bus.req_op, bus.req_addr[1:0])) begin
            stateNext     = RESP;
            respValidNext = 1'b1;
            respErrNext   = 1'b1;
            errInc        = 1'b1;
          end else if (bus.req_op == OpSw) begin
            stateNext    = WR;
            memWriteNext = 1'b1;
            memAddrNext  = {bus.req_addr[31:2], 2'b00};
            memWdataNext = bus.req_wdata;
          end else begin
            stateNext   = RD;
            memReadNext = 1'b1;
            memAddrNext = {bus.req_addr[31:2], 2'b00};
          end
        end
      end
      RD: stateNext = ((opR == OpSb) || (opR == OpSh)) ? MERGE : LEXT;
      LEXT: begin
        stateNext     = RESP;
        respValidNext = 1'b1;
        respDataNext  = extendLoad(opR, addrR[1:0], bus.mem_rdata);
      end
      MERGE: begin
        stateNext    = WR;
        memWriteNext = 1'b1;
        memAddrNext  = {addrR[31:2], 2'b00};
        memWdataNext = mergeStore(opR, addrR[1:0], bus.mem_rdata, wdataR);
      end
      WR: begin
        stateNext     = RESP;
        respValidNext = 1'b1;
      end
      RESP: begin
        stateNext    = IDLE;
        reqReadyNext = 1'b1;
      end
      default: begin
        stateNext    = IDLE;
        reqReadyNext = 1'b1;
      end
    endcase
  end

  // State, output registers and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      reqReady  <= 1'b1;
      respValid <= 1'b0;
      respData  <= '0;
      respErr   <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      errCount  <= '0;
    end else begin
      state     <= stateNext;
      reqReady  <= reqReadyNext;
      respValid <= respValidNext;
      respData  <= respDataNext;
      respErr   <= respErrNext;
      memAddr   <= memAddrNext;
      memWdata  <= memWdataNext;
      memRead   <= memReadNext;
      memWrite  <= memWriteNext;
      if (errInc && (errCount != {CountWidth{1'b1}})) begin
        errCount <= errCount + CountWidth'(1);
      end
    end
  end

  // Capture the accepted request; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opR    <= '0;
      addrR  <= '0;
      wdataR <= '0;
    end else if (latch) begin
      opR    <= bus.req_op;
      addrR  <= bus.req_addr;
      wdataR <= bus.req_wdata[15:0];
    end
  end

  assign bus.req_ready  = reqReady;
  assign bus.resp_valid = respValid;
  assign bus.resp_data  = respData;
  assign bus.resp_err   = respErr;
  assign bus.mem_addr   = memAddr;
  assign bus.mem_wdata  = memWdata;
  assign bus.mem_read   = memRead;
  assign bus.mem_write  = memWrite;
  assign err_count      = errCount;
endmodule
